// File: rtl/add_serial_arb.sv
// -----------------------------------------------------------------------------
// add_serial_arb
//   Round-robin arbiter in front of one shared bit-serial adder. A granted
//   requester's operands are captured, added LSB-first over WIDTH cycles, and
//   the sum is returned with a one-cycle done pulse to that requester.
//
// Parameters
//   NREQ  : number of requesters (2..8)
//   WIDTH : operand / sum width in bits (2..32)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   req   in   [NREQ]        per-requester request level
//   a     in   [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   b     in   [NREQ*WIDTH]  operand B, same packing
//   gnt   out  [NREQ]        one-hot grant pulse (one cycle)
//   done  out  [NREQ]        one-hot completion pulse (one cycle)
//   sum   out  [WIDTH]       result of the most recent completed addition
//   busy  out                high while an addition is in progress
//   cout  out                final carry of the most recent addition
//                            (only when ADD_SERIAL_ARB_COUT_EN is defined)
//
// Build option
//   ADD_SERIAL_ARB_COUT_EN : adds the cout port and its holding register.
// -----------------------------------------------------------------------------
module add_serial_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a,
  input  logic [NREQ*WIDTH-1:0]   b,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        sum,
  output logic                    busy
`ifdef ADD_SERIAL_ARB_COUT_EN
  ,
  output logic                    cout
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ADD  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic              r_carry;
  logic [CW-1:0]     r_count;

  logic [PW-1:0]     w_win;
  logic              w_any;
  logic              w_last;
  logic              w_s;
  logic              w_c;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [NREQ-1:0]   w_done_nxt;

  // Requester index reached by stepping 'off' places up from 'base', wrapping.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NREQ) begin
      t = t - NREQ;
    end else begin
      t = t;
    end
    return PW'(t);
  endfunction

  // Round-robin winner search; scanning downward lets the closest-to-ptr hit win.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[rr_idx(r_ptr, i)]) begin
        w_win = rr_idx(r_ptr, i);
        w_any = 1'b1;
      end else begin
        w_any = w_any;
      end
    end
  end

  // Full-adder slice on the current LSBs plus the stored carry.
  always_comb begin
    w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_last = (r_count == CW'(WIDTH - 1));
  end

  // Next-state and next-pulse logic; pulses default low so they self-clear.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ADD;
          w_gnt_nxt   = ONE_HOT0 << w_win;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADD: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = ONE_HOT0 << r_owner;
        end else begin
          w_state_nxt = S_ADD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered output pulses and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt  <= '0;
      done <= '0;
      busy <= 1'b0;
    end else begin
      gnt  <= w_gnt_nxt;
      done <= w_done_nxt;
      busy <= (w_state_nxt == S_ADD);
    end
  end

  // Operand capture at grant, serial shift/accumulate in ADD, result on last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      sum     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= a[w_win*WIDTH +: WIDTH];
            r_b     <= b[w_win*WIDTH +: WIDTH];
            r_owner <= w_win;
            r_carry <= 1'b0;
            r_count <= '0;
          end else begin
            r_count <= r_count;
          end
        end
        S_ADD: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_acc   <= {w_s, r_acc[WIDTH-1:1]};
          r_carry <= w_c;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            sum   <= {w_s, r_acc[WIDTH-1:1]};
            // Owner drops to the back of the queue.
            r_ptr <= rr_idx(r_owner, 1);
          end else begin
            sum   <= sum;
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

`ifdef ADD_SERIAL_ARB_COUT_EN
  // Final carry held alongside sum until the next completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cout <= 1'b0;
    end else if (r_state == S_ADD && w_last) begin
      cout <= w_c;
    end else begin
      cout <= cout;
    end
  end
`endif

endmodule

// File: tb/tb_add_serial_arb.sv
module tb_add_serial_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a;
  logic [NREQ*WIDTH-1:0] b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      sum;
  logic                  busy;
`ifdef ADD_SERIAL_ARB_COUT_EN
  logic                  cout;
`endif

  int n_checks;
  int n_errors;

  add_serial_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a    (a),
    .b    (b),
    .gnt  (gnt),
    .done (done),
    .sum  (sum),
    .busy (busy)
`ifdef ADD_SERIAL_ARB_COUT_EN
    ,
    .cout (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [7:0] av, input logic [7:0] bv);
    a[idx*WIDTH +: WIDTH] = av;
    b[idx*WIDTH +: WIDTH] = bv;
  endtask

  // Runs the ADD phase after a grant already seen: 7 quiet cycles, then done.
  task automatic finish_op(input string tag, input int idx, input logic [7:0] exp_sum);
    int early;
    early = 0;
    for (int k = 0; k < WIDTH - 1; k++) begin
      tick();
      if (done != 4'b0000 || gnt != 4'b0000) early++;
    end
    check_val({tag, "_quiet"}, early, 0);
    tick();
    check_val({tag, "_done"}, done, 4'b0001 << idx);
    check_val({tag, "_sum"}, sum, exp_sum);
    check_val({tag, "_busy0"}, busy, 1'b0);
  endtask

  logic [7:0] fa [4];
  logic [7:0] fb [4];
  logic [7:0] fs [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    req = '0;
    a   = '0;
    b   = '0;
    repeat (2) tick();

    // Reset state
    check_val("rst_gnt", gnt, 4'b0000);
    check_val("rst_done", done, 4'b0000);
    check_val("rst_sum", sum, 8'h00);
    check_val("rst_busy", busy, 1'b0);
`ifdef ADD_SERIAL_ARB_COUT_EN
    check_val("rst_cout", cout, 1'b0);
`endif
    rst = 1'b1;
    tick();
    check_val("idle_gnt", gnt, 4'b0000);

    // Single request: 0x3C + 0x05 = 0x41
    set_ops(0, 8'h3C, 8'h05);
    req = 4'b0001;
    tick();
    check_val("single_gnt", gnt, 4'b0001);
    check_val("single_busy", busy, 1'b1);
    req = 4'b0000;
    finish_op("single", 0, 8'h41);
    tick();
    check_val("single_done_clr", done, 4'b0000);
    check_val("single_sum_hold", sum, 8'h41);

    // Overflow: 0xFF + 0x01 = 0x00 carry 1 (ptr now 1)
    set_ops(1, 8'hFF, 8'h01);
    req = 4'b0010;
    tick();
    check_val("ovf_gnt", gnt, 4'b0010);
    req = 4'b0000;
    finish_op("ovf", 1, 8'h00);
`ifdef ADD_SERIAL_ARB_COUT_EN
    check_val("ovf_cout", cout, 1'b1);
`endif

    // Fairness: reset ptr to 0, then all four held high
    rst = 1'b0;
    #1;
    rst = 1'b1;
    fa[0] = 8'h10; fb[0] = 8'h20; fs[0] = 8'h30;
    fa[1] = 8'h7F; fb[1] = 8'h01; fs[1] = 8'h80;
    fa[2] = 8'hAA; fb[2] = 8'h55; fs[2] = 8'hFF;
    fa[3] = 8'hC8; fb[3] = 8'h64; fs[3] = 8'h2C;
    for (int i = 0; i < 4; i++) set_ops(i, fa[i], fb[i]);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val($sformatf("fair%0d_gnt", k), gnt, 4'b0001 << (k % 4));
      finish_op($sformatf("fair%0d", k), k % 4, fs[k % 4]);
    end
    req = 4'b0000;
    tick();
    check_val("fair_stop_gnt", gnt, 4'b0000);

    // Operand isolation on requester 2 (ptr now 1): 0x12 + 0x34 = 0x46
    set_ops(2, 8'h12, 8'h34);
    req = 4'b0100;
    tick();
    check_val("iso_gnt", gnt, 4'b0100);
    req = 4'b0000;
    set_ops(2, 8'hFF, 8'hFF);
    finish_op("iso", 2, 8'h46);

    // Reset in the 4th ADD cycle of an operation for requester 0
    set_ops(0, 8'h55, 8'h0A);
    req = 4'b0001;
    tick();
    check_val("rmid_gnt", gnt, 4'b0001);
    req = 4'b0000;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_val("rmid_gnt0", gnt, 4'b0000);
    check_val("rmid_done0", done, 4'b0000);
    check_val("rmid_sum0", sum, 8'h00);
    check_val("rmid_busy0", busy, 1'b0);
`ifdef ADD_SERIAL_ARB_COUT_EN
    check_val("rmid_cout0", cout, 1'b0);
`endif
    tick();
    rst = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (done != 4'b0000 || busy != 1'b0) seen++;
      end
      check_val("rmid_no_done", seen, 0);
    end
    set_ops(3, 8'h9C, 8'h4B);
    req = 4'b1000;
    tick();
    check_val("rmid_gnt3", gnt, 4'b1000);
    req = 4'b0000;
    finish_op("rmid3", 3, 8'hE7);

    // Late arrival: req[1] rises while 0 is served (ptr now 0)
    set_ops(0, 8'h21, 8'h43);
    req = 4'b0001;
    tick();
    check_val("late_gnt0", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    tick();
    set_ops(1, 8'h0F, 8'h0F);
    req = 4'b0010;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < WIDTH - 3; k++) begin
        tick();
        if (gnt != 4'b0000 || done != 4'b0000) stray++;
      end
      check_val("late_no_early", stray, 0);
    end
    tick();
    check_val("late_done0", done, 4'b0001);
    check_val("late_sum0", sum, 8'h64);
    check_val("late_gnt_quiet", gnt, 4'b0000);
    tick();
    check_val("late_gnt1", gnt, 4'b0010);
    req = 4'b0000;
    finish_op("late1", 1, 8'h1E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

endmodule
